// File: rtl/hall_call_dispatcher.sv
// hall_call_dispatcher: per-floor hall call FSMs with round-robin, cost-based dispatch to two cars
module hall_call_dispatcher #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] hall_req,
  input  logic [2:0] ffloor,
  input  logic [2:0] sfloor,
  input  logic       fgoing_up,
  input  logic       fgoing_down,
  input  logic       sgoing_up,
  input  logic       sgoing_down,
  input  logic       fdoor_open,
  input  logic       sdoor_open,
  output logic [4:0] fassign,
  output logic [4:0] sassign,
  output logic [4:0] hall_lamp,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, PENDING, ASG_F, ASG_S} st_t;
  st_t        st     [0:4];
  st_t        st_nx  [0:4];
  logic [7:0] cnt    [0:4];
  logic [7:0] cnt_nx [0:4];
  logic [4:0] re, re_nx, own, own_nx, svc, pend_ok, is_f, is_s, is_p;
  logic [2:0] ptr, ptr_nx, sel;
  logic       tie, tie_nx, found, to_s;
  logic [3:0] fcost, scost;

  // Out-of-range car floors cost as floor 5; conflicting direction flags count as idle.
  function automatic logic [3:0] cost(input logic [2:0] cf_raw, input logic up, input logic dn,
                                      input logic [2:0] k);
    logic [2:0] cf;
    logic [3:0] d;
    logic       mu, md;
    cf = (cf_raw >= 3'd1 && cf_raw <= 3'd5) ? cf_raw : 3'd5;
    d  = cf > k ? {1'b0, cf - k} : {1'b0, k - cf};
    mu = up & ~dn;
    md = dn & ~up;
    return ((~mu & ~md) || (mu && k > cf) || (md && k < cf)) ? d : d + 4'd4;
  endfunction

  // Floor index i steps after p, wrapping 4 -> 0.
  function automatic logic [2:0] rr(input logic [2:0] p, input logic [2:0] i);
    logic [3:0] s;
    s = {1'b0, p} + {1'b0, i};
    return s >= 4'd5 ? 3'(s - 4'd5) : s[2:0];
  endfunction

  // Service matches and per-floor state decodes feeding dispatch and the output register.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      svc[k]     = (ffloor == 3'(k + 1) && fdoor_open) || (sfloor == 3'(k + 1) && sdoor_open);
      pend_ok[k] = st[k] == PENDING && !svc[k];
      is_f[k]    = st[k] == ASG_F;
      is_s[k]    = st[k] == ASG_S;
      is_p[k]    = st[k] == PENDING;
    end
  end

  // Round-robin pick of one pending floor, car choice, and per-floor next state.
  always_comb begin
    ptr_nx = ptr;
    tie_nx = tie;
    re_nx  = re;
    own_nx = own;
    found  = 1'b0;
    sel    = 3'd0;
    for (int i = 1; i <= 5; i++) begin
      if (!found && pend_ok[rr(ptr, 3'(i))]) begin
        found = 1'b1;
        sel   = rr(ptr, 3'(i));
      end
    end
    fcost = cost(ffloor, fgoing_up, fgoing_down, sel + 3'd1);
    scost = cost(sfloor, sgoing_up, sgoing_down, sel + 3'd1);
    to_s  = re[sel] ? ~own[sel] : fcost != scost ? scost < fcost : tie;
    if (found) begin
      ptr_nx      = sel;
      tie_nx      = (!re[sel] && fcost == scost) ? ~tie : tie;
      own_nx[sel] = to_s;
    end
    for (int k = 0; k < 5; k++) begin
      st_nx[k]  = st[k];
      cnt_nx[k] = cnt[k];
      if (st[k] == IDLE && hall_req[k]) begin
        st_nx[k] = PENDING;
      end else if (st[k] == PENDING && found && sel == 3'(k)) begin
        st_nx[k]  = to_s ? ASG_S : ASG_F;
        cnt_nx[k] = 8'd0;
      end else if (st[k] == ASG_F || st[k] == ASG_S) begin
        if (!re[k] && cnt[k] == 8'(TIMEOUT - 1)) begin
          st_nx[k]  = PENDING;
          re_nx[k]  = 1'b1;
          cnt_nx[k] = 8'd0;
        end else begin
          cnt_nx[k] = cnt[k] == 8'hff ? cnt[k] : cnt[k] + 8'd1;
        end
      end
      if (svc[k]) begin
        st_nx[k]  = IDLE;
        cnt_nx[k] = 8'd0;
        re_nx[k]  = 1'b0;
      end
    end
  end

  // Call state, RR pointer (resets to floor 5) and tie-break flop (resets to car F).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 5; k++) begin
        st[k]  <= IDLE;
        cnt[k] <= 8'd0;
      end
      re  <= '0;
      own <= '0;
      ptr <= 3'd4;
      tie <= 1'b0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        st[k]  <= st_nx[k];
        cnt[k] <= cnt_nx[k];
      end
      re  <= re_nx;
      own <= own_nx;
      ptr <= ptr_nx;
      tie <= tie_nx;
    end
  end

  // Registered view of the call state, one cycle behind it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fassign   <= '0;
      sassign   <= '0;
      hall_lamp <= '0;
      busy      <= 1'b0;
    end else begin
      fassign   <= is_f;
      sassign   <= is_s;
      hall_lamp <= is_f | is_s | is_p;
      busy      <= |is_p;
    end
  end
endmodule

// File: tb/tb_hall_call_dispatcher.sv
// tb_hall_call_dispatcher: directed scenario checks for the hall call dispatcher
module tb_hall_call_dispatcher;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] hall_req = '0;
  logic [2:0] ffloor = 3'd1, sfloor = 3'd5;
  logic       fgoing_up = 0, fgoing_down = 0, sgoing_up = 0, sgoing_down = 0;
  logic       fdoor_open = 0, sdoor_open = 0;
  logic [4:0] fassign, sassign, hall_lamp;
  logic       busy;
  int         checks = 0, failures = 0;

  hall_call_dispatcher #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .hall_req(hall_req), .ffloor(ffloor), .sfloor(sfloor),
    .fgoing_up(fgoing_up), .fgoing_down(fgoing_down), .sgoing_up(sgoing_up),
    .sgoing_down(sgoing_down), .fdoor_open(fdoor_open), .sdoor_open(sdoor_open),
    .fassign(fassign), .sassign(sassign), .hall_lamp(hall_lamp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cars(input logic [2:0] ff, input logic fu, input logic fd,
                          input logic [2:0] sf, input logic su, input logic sd);
    ffloor = ff; fgoing_up = fu; fgoing_down = fd;
    sfloor = sf; sgoing_up = su; sgoing_down = sd;
    fdoor_open = 0; sdoor_open = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    hall_req = '0;
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    hall_req = 5'h1f;
    tick();
    tick();
    checks++;
    if ({fassign, sassign, hall_lamp, busy} !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: got %h expected 0", {fassign, sassign, hall_lamp, busy});
    end
    hall_req = '0;
    reset = 1;
  endtask

  task automatic test_basic_latency();
    do_reset();
    set_cars(3'd1, 0, 0, 3'd5, 0, 0);
    hall_req = 5'b00100;
    tick();
    hall_req = '0;
    checks++;
    if (hall_lamp !== 5'b0) begin
      failures++; $display("FAIL basic_lamp_n: got %b expected 00000", hall_lamp);
    end
    tick();
    checks++;
    if (hall_lamp !== 5'b00100 || busy !== 1'b1 || fassign !== 5'b0) begin
      failures++;
      $display("FAIL basic_n1: lamp=%b busy=%b fassign=%b expected 00100 1 00000", hall_lamp, busy, fassign);
    end
    tick();
    checks++;
    if (fassign !== 5'b00100 || sassign !== 5'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_n2: fassign=%b sassign=%b busy=%b expected 00100 00000 0", fassign, sassign, busy);
    end
  endtask

  task automatic test_cost_and_service();
    do_reset();
    set_cars(3'd3, 1, 0, 3'd3, 0, 0);
    hall_req = 5'b00001;
    tick();
    hall_req = '0;
    tick();
    tick();
    checks++;
    if (sassign !== 5'b00001 || fassign !== 5'b0) begin
      failures++;
      $display("FAIL cost_pick: fassign=%b sassign=%b expected 00000 00001", fassign, sassign);
    end
    sfloor = 3'd1;
    sdoor_open = 1;
    tick();
    sdoor_open = 0;
    tick();
    checks++;
    if (sassign !== 5'b0 || hall_lamp !== 5'b0) begin
      failures++;
      $display("FAIL service_clear: sassign=%b lamp=%b expected 00000 00000", sassign, hall_lamp);
    end
  endtask

  task automatic test_tie_break();
    do_reset();
    set_cars(3'd3, 0, 0, 3'd3, 0, 0);
    hall_req = 5'b01010;
    tick();
    hall_req = '0;
    tick();
    checks++;
    if (hall_lamp !== 5'b01010 || busy !== 1'b1) begin
      failures++; $display("FAIL tie_lamp: lamp=%b busy=%b expected 01010 1", hall_lamp, busy);
    end
    tick();
    checks++;
    if (fassign !== 5'b00010 || sassign !== 5'b0) begin
      failures++;
      $display("FAIL tie_first: fassign=%b sassign=%b expected 00010 00000", fassign, sassign);
    end
    tick();
    checks++;
    if (fassign !== 5'b00010 || sassign !== 5'b01000) begin
      failures++;
      $display("FAIL tie_second: fassign=%b sassign=%b expected 00010 01000", fassign, sassign);
    end
  endtask

  task automatic test_timeout();
    logic bad;
    do_reset();
    set_cars(3'd2, 0, 0, 3'd5, 0, 0);
    hall_req = 5'b00010;
    tick();
    hall_req = '0;
    tick();
    tick();
    checks++;
    if (fassign !== 5'b00010) begin
      failures++; $display("FAIL timeout_assign: fassign=%b expected 00010", fassign);
    end
    repeat (3) tick();
    checks++;
    if (fassign !== 5'b00010) begin
      failures++; $display("FAIL timeout_hold: fassign=%b expected 00010", fassign);
    end
    tick();
    checks++;
    if (fassign !== 5'b0 || sassign !== 5'b0 || busy !== 1'b1 || hall_lamp !== 5'b00010) begin
      failures++;
      $display("FAIL timeout_pending: f=%b s=%b busy=%b lamp=%b expected 00000 00000 1 00010",
               fassign, sassign, busy, hall_lamp);
    end
    tick();
    checks++;
    if (sassign !== 5'b00010 || fassign !== 5'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_reassign: f=%b s=%b busy=%b expected 00000 00010 0", fassign, sassign, busy);
    end
    bad = 0;
    repeat (300) begin
      tick();
      if (sassign !== 5'b00010 || fassign !== 5'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL timeout_sticky: f=%b s=%b expected 00000 00010 for 300 cycles", fassign, sassign);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_cars(3'd1, 0, 0, 3'd5, 0, 0);
    hall_req = 5'b00111;
    tick();
    hall_req = '0;
    repeat (4) tick();
    checks++;
    if (hall_lamp !== 5'b00111 || (fassign | sassign) === 5'b0) begin
      failures++;
      $display("FAIL areset_pre: lamp=%b assigned=%b expected 00111 nonzero", hall_lamp, fassign | sassign);
    end
    #2 reset = 0;
    #1;
    checks++;
    if ({fassign, sassign, hall_lamp, busy} !== 16'h0) begin
      failures++;
      $display("FAIL areset_async: got %h expected 0", {fassign, sassign, hall_lamp, busy});
    end
    @(negedge clk);
    reset = 1;
    hall_req = 5'b10000;
    tick();
    hall_req = '0;
    checks++;
    if (hall_lamp !== 5'b0) begin
      failures++; $display("FAIL areset_n: lamp=%b expected 00000", hall_lamp);
    end
    tick();
    checks++;
    if (hall_lamp !== 5'b10000) begin
      failures++; $display("FAIL areset_n1: lamp=%b expected 10000", hall_lamp);
    end
    tick();
    checks++;
    if (sassign !== 5'b10000 || fassign !== 5'b0) begin
      failures++;
      $display("FAIL areset_n2: fassign=%b sassign=%b expected 00000 10000", fassign, sassign);
    end
  endtask

  task automatic test_press_during_service();
    logic bad;
    do_reset();
    set_cars(3'd4, 0, 0, 3'd1, 0, 0);
    fdoor_open = 1;
    hall_req = 5'b01000;
    tick();
    hall_req = '0;
    fdoor_open = 0;
    bad = 0;
    repeat (4) begin
      tick();
      if (hall_lamp[3] !== 1'b0 || fassign[3] !== 1'b0 || sassign[3] !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL press_serviced: lamp=%b expected bit3 clear", hall_lamp);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    set_cars(3'd7, 0, 0, 3'd1, 0, 0);
    fdoor_open = 1;
    hall_req = 5'b01000;
    tick();
    hall_req = '0;
    tick();
    tick();
    checks++;
    if (fassign !== 5'b01000 || hall_lamp !== 5'b01000) begin
      failures++;
      $display("FAIL oor_floor: fassign=%b lamp=%b expected 01000 01000", fassign, hall_lamp);
    end
    fdoor_open = 0;
  endtask

  task automatic test_both_dirs_idle();
    do_reset();
    set_cars(3'd3, 1, 1, 3'd5, 0, 0);
    hall_req = 5'b00001;
    tick();
    hall_req = '0;
    tick();
    tick();
    checks++;
    if (fassign !== 5'b00001 || sassign !== 5'b0) begin
      failures++;
      $display("FAIL both_dirs: fassign=%b sassign=%b expected 00001 00000", fassign, sassign);
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_cost_and_service();
    test_tie_break();
    test_timeout();
    test_async_reset();
    test_press_during_service();
    test_out_of_range();
    test_both_dirs_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
